// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-wide RAM port arbiter.
// Holds the MEM access size codes, the arbiter state encoding and the byte-count helper.
package mem_arbiter_pkg;

    localparam logic RST_ENABLE = 1'b0;

    localparam int MEM_SEL_W = 2;
    localparam logic [MEM_SEL_W-1:0] MEM_NOP = 2'b00;
    localparam logic [MEM_SEL_W-1:0] MEM_B   = 2'b01;
    localparam logic [MEM_SEL_W-1:0] MEM_H   = 2'b10;
    localparam logic [MEM_SEL_W-1:0] MEM_W   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IF_RD  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_DONE   = 3'd4
    } arb_state_t;

    function automatic logic [2:0] sel_bytes(input logic [MEM_SEL_W-1:0] sel);
        case (sel)
            MEM_B:   return 3'd1;
            MEM_H:   return 3'd2;
            MEM_W:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and the MEM stage,
// walking each multi-byte access one byte per cycle and pulsing a done strobe at the end.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic              stallreq_mem,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    arb_state_t        state_reg, state_next;
    logic [2:0]        cnt_reg, cnt_next;
    logic [2:0]        nbytes_reg, nbytes_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [31:0]       buf_reg, buf_next;
    logic [ADDR_W-1:0] ram_a_reg, ram_a_next;
    logic [7:0]        ram_dout_reg, ram_dout_next;
    logic              ram_wr_reg, ram_wr_next;
    logic              if_done_reg, if_done_next;
    logic              mem_done_reg, mem_done_next;
    logic [31:0]       if_inst_reg, if_inst_next;
    logic [31:0]       mem_rdata_reg, mem_rdata_next;

    logic [31:0]       merged;
    logic [1:0]        wr_idx;
    logic              addr_more;

    // In a read, cycle cnt carries the byte addressed at cnt-1, so it lands in lane cnt-1.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[8*gi +: 8] = (cnt_reg == 3'(gi + 1)) ? ram_din : buf_reg[8*gi +: 8];
        end
    endgenerate

    assign wr_idx    = cnt_reg[1:0] + 2'd1;
    assign addr_more = (cnt_reg + 3'd1) < nbytes_reg;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        nbytes_next    = nbytes_reg;
        wdata_next     = wdata_reg;
        buf_next       = buf_reg;
        ram_a_next     = ram_a_reg;
        ram_dout_next  = ram_dout_reg;
        ram_wr_next    = 1'b0;
        if_done_next   = 1'b0;
        mem_done_next  = 1'b0;
        if_inst_next   = if_inst_reg;
        mem_rdata_next = mem_rdata_reg;

        case (state_reg)
            ST_IDLE: begin
                if (mem_req && (mem_sel != MEM_NOP)) begin
                    state_next  = mem_we ? ST_MEM_WR : ST_MEM_RD;
                    nbytes_next = sel_bytes(mem_sel);
                    cnt_next    = '0;
                    buf_next    = '0;
                    wdata_next  = mem_wdata;
                    ram_a_next  = mem_addr;
                    if (mem_we) begin
                        ram_wr_next   = 1'b1;
                        ram_dout_next = mem_wdata[7:0];
                    end
                end else if (if_req && !if_flush) begin
                    state_next  = ST_IF_RD;
                    nbytes_next = 3'd4;
                    cnt_next    = '0;
                    buf_next    = '0;
                    ram_a_next  = if_addr;
                end
            end

            ST_IF_RD, ST_MEM_RD: begin
                if ((state_reg == ST_IF_RD) && if_flush) begin
                    state_next = ST_IDLE;
                end else begin
                    buf_next = merged;
                    cnt_next = cnt_reg + 3'd1;
                    if (addr_more) begin
                        ram_a_next = ram_a_reg + ADDR_W'(1);
                    end
                    // The last byte arrives one cycle after its address; finish on that cycle.
                    if (cnt_reg == nbytes_reg) begin
                        state_next = ST_DONE;
                        if (state_reg == ST_IF_RD) begin
                            if_done_next = 1'b1;
                            if_inst_next = merged;
                        end else begin
                            mem_done_next  = 1'b1;
                            mem_rdata_next = merged;
                        end
                    end
                end
            end

            ST_MEM_WR: begin
                if (addr_more) begin
                    ram_wr_next   = 1'b1;
                    ram_a_next    = ram_a_reg + ADDR_W'(1);
                    ram_dout_next = wdata_reg[8*wr_idx +: 8];
                    cnt_next      = cnt_reg + 3'd1;
                end else begin
                    state_next    = ST_DONE;
                    mem_done_next = 1'b1;
                end
            end

            ST_DONE: state_next = ST_IDLE;

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            nbytes_reg    <= '0;
            wdata_reg     <= '0;
            buf_reg       <= '0;
            ram_a_reg     <= '0;
            ram_dout_reg  <= '0;
            ram_wr_reg    <= 1'b0;
            if_done_reg   <= 1'b0;
            mem_done_reg  <= 1'b0;
            if_inst_reg   <= '0;
            mem_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            nbytes_reg    <= nbytes_next;
            wdata_reg     <= wdata_next;
            buf_reg       <= buf_next;
            ram_a_reg     <= ram_a_next;
            ram_dout_reg  <= ram_dout_next;
            ram_wr_reg    <= ram_wr_next;
            if_done_reg   <= if_done_next;
            mem_done_reg  <= mem_done_next;
            if_inst_reg   <= if_inst_next;
            mem_rdata_reg <= mem_rdata_next;
        end
    end

    assign if_done      = if_done_reg;
    assign if_inst      = if_inst_reg;
    assign mem_done     = mem_done_reg;
    assign mem_rdata    = mem_rdata_reg;
    assign ram_a        = ram_a_reg;
    assign ram_dout     = ram_dout_reg;
    assign ram_wr       = ram_wr_reg;
    assign stallreq_mem = mem_req && (mem_sel != MEM_NOP) && !mem_done_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle corner sequences
// and randomized transactions checked against a transaction-level RAM/timing model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_done;
    logic [31:0] if_addr, if_inst;
    logic        mem_req, mem_we, mem_done, stallreq_mem;
    logic [1:0]  mem_sel;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  ram_din, ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_inst(if_inst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .stallreq_mem(stallreq_mem),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    // RAM storage is folded to 512 bytes; every address the bench uses maps to a distinct slot.
    function automatic logic [8:0] midx(input logic [31:0] a);
        return {a[12], a[7:0]};
    endfunction

    function automatic logic [7:0] init_byte(input logic [8:0] i);
        case (i)
            9'h100:         return 8'h13;
            9'h101:         return 8'h05;
            9'h102, 9'h103: return 8'h00;
            9'h020:         return 8'h80;
            9'h1FE:         return 8'h11;
            9'h1FF:         return 8'h22;
            9'h000:         return 8'h33;
            9'h001:         return 8'h44;
            default:        return i[7:0] ^ {i[8], 7'h2B};
        endcase
    endfunction

    // RAM responder: data for the address presented in one cycle appears the next cycle.
    logic [7:0]   ram_mem [512];
    logic [511:0] ram_valid;
    logic         ram_clr;
    always @(posedge clk) begin
        if (ram_clr) begin
            ram_valid <= '0;
        end else if (ram_wr) begin
            ram_mem[midx(ram_a)]   <= ram_dout;
            ram_valid[midx(ram_a)] <= 1'b1;
        end
        ram_din <= ram_valid[midx(ram_a)] ? ram_mem[midx(ram_a)] : init_byte(midx(ram_a));
    end

    // Reference model state
    logic [7:0]  ref_mem [512];
    logic [31:0] model_last_if, model_last_mem;
    bit          model_mem_known;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_txn = 0;

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] w = '0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = ref_mem[midx(a + 32'(k))];
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        bit          do_if;
        logic [31:0] if_a;
        bit          do_mem;
        bit          we;
        logic [1:0]  sel;
        logic [31:0] m_a;
        logic [31:0] wd;
        bit          flush;
    } txn_t;

    typedef struct {
        txn_t        t;
        int          if_cyc;
        logic [31:0] if_d;
        int          mem_cyc;
        logic [31:0] mem_d;
    } vec_t;

    // Starts one cycle after a clock edge with the DUT idle; returns one cycle after the last done.
    task automatic run_txn(input txn_t t, output int if_cyc, output logic [31:0] if_d,
                           output int mem_cyc, output logic [31:0] mem_d);
        int          n_m, mem_exp, if_exp, if_start, last;
        logic [31:0] exp_m, exp_i;
        bit          s_v [64];
        bit          s_wr [64];
        logic [31:0] s_a [64];
        logic [7:0]  s_do [64];

        for (int c = 0; c < 64; c++) begin
            s_v[c] = 1'b0; s_wr[c] = 1'b0; s_a[c] = '0; s_do[c] = '0;
        end
        n_m = (t.sel == 2'd1) ? 1 : (t.sel == 2'd2) ? 2 : 4;
        mem_exp = -1; if_exp = -1; if_start = 0; exp_m = '0; exp_i = '0;
        if (t.do_mem) begin
            mem_exp = t.we ? n_m + 1 : n_m + 2;
            exp_m   = ref_word(t.m_a, n_m);
            for (int k = 0; k < n_m; k++) begin
                s_v[1+k] = 1'b1; s_wr[1+k] = t.we; s_a[1+k] = t.m_a + 32'(k);
                s_do[1+k] = t.wd[8*k +: 8];
                if (t.we) ref_mem[midx(t.m_a + 32'(k))] = t.wd[8*k +: 8];
            end
            if_start = mem_exp + 1;
        end
        if (t.do_if) begin
            if_exp = if_start + 6;
            exp_i  = ref_word(t.if_a, 4);
            for (int k = 0; k < 4; k++) begin
                s_v[if_start+1+k] = 1'b1; s_a[if_start+1+k] = t.if_a + 32'(k);
            end
        end
        last = (mem_exp > if_exp) ? mem_exp : if_exp;

        $display("txn %0d: if=%0b a=%h mem=%0b we=%0b sel=%0d a=%h wd=%h flush=%0b",
                 n_txn, t.do_if, t.if_a, t.do_mem, t.we, t.sel, t.m_a, t.wd, t.flush);
        n_txn++;

        if_req = t.do_if; if_addr = t.if_a; if_flush = t.flush && !t.do_if;
        mem_req = t.do_mem; mem_we = t.we; mem_sel = t.sel; mem_addr = t.m_a; mem_wdata = t.wd;
        if_cyc = -1; mem_cyc = -1; if_d = '0; mem_d = '0;

        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            check($sformatf("t%0d if_done c%0d", n_txn, c), 32'(if_done), 32'(c == if_exp));
            check($sformatf("t%0d mem_done c%0d", n_txn, c), 32'(mem_done), 32'(c == mem_exp));
            check($sformatf("t%0d stall c%0d", n_txn, c), 32'(stallreq_mem),
                  32'(t.do_mem && c < mem_exp));
            check($sformatf("t%0d ram_wr c%0d", n_txn, c), 32'(ram_wr), 32'(s_v[c] && s_wr[c]));
            if (s_v[c]) check($sformatf("t%0d ram_a c%0d", n_txn, c), ram_a, s_a[c]);
            if (s_v[c] && s_wr[c])
                check($sformatf("t%0d ram_dout c%0d", n_txn, c), 32'(ram_dout), 32'(s_do[c]));
            if (if_done)  begin if_cyc = c;  if_d = if_inst;    end
            if (mem_done) begin mem_cyc = c; mem_d = mem_rdata; end
            @(posedge clk); #1;
            if (if_cyc >= 0)  if_req = 1'b0;
            if (mem_cyc >= 0) mem_req = 1'b0;
        end
        if_req = 1'b0; mem_req = 1'b0; if_flush = 1'b0;

        if (t.do_mem && !t.we) begin
            check($sformatf("t%0d mem_rdata", n_txn), mem_d, exp_m);
            model_last_mem = exp_m; model_mem_known = 1'b1;
        end
        if (t.do_mem && t.we) model_mem_known = 1'b0;
        if (t.do_if) begin
            check($sformatf("t%0d if_inst", n_txn), if_d, exp_i);
            model_last_if = exp_i;
        end
        check($sformatf("t%0d if_inst hold", n_txn), if_inst, model_last_if);
        if (model_mem_known) check($sformatf("t%0d mem_rdata hold", n_txn), mem_rdata, model_last_mem);
    endtask

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        if (r < 5)  return 32'($urandom_range(0, 'hF0));
        return 32'h1000 + 32'($urandom_range(0, 'hEF));
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [8];
        txn_t        t;
        int          ic, mc;
        logic [31:0] id, md;

        vecs[0] = '{t:'{1, 32'h1000, 0, 0, 2'd0, 32'h0, 32'h0, 0},
                    if_cyc:6, if_d:32'h0000_0513, mem_cyc:-1, mem_d:32'h0};
        vecs[1] = '{t:'{1, 32'h1000, 1, 0, 2'd1, 32'h20, 32'h0, 0},
                    if_cyc:10, if_d:32'h0000_0513, mem_cyc:3, mem_d:32'h0000_0080};
        vecs[2] = '{t:'{0, 32'h0, 1, 1, 2'd2, 32'h30, 32'hDEAD_BEEF, 0},
                    if_cyc:-1, if_d:32'h0, mem_cyc:3, mem_d:32'h0};
        vecs[3] = '{t:'{0, 32'h0, 1, 0, 2'd3, 32'hFFFF_FFFE, 32'h0, 0},
                    if_cyc:-1, if_d:32'h0, mem_cyc:6, mem_d:32'h4433_2211};
        vecs[4] = '{t:'{0, 32'h0, 1, 1, 2'd3, 32'h50, 32'hCAFE_F00D, 0},
                    if_cyc:-1, if_d:32'h0, mem_cyc:5, mem_d:32'h0};
        vecs[5] = '{t:'{0, 32'h0, 1, 0, 2'd3, 32'h50, 32'h0, 0},
                    if_cyc:-1, if_d:32'h0, mem_cyc:6, mem_d:32'hCAFE_F00D};
        vecs[6] = '{t:'{0, 32'h0, 1, 1, 2'd1, 32'h31, 32'h0000_00A5, 0},
                    if_cyc:-1, if_d:32'h0, mem_cyc:2, mem_d:32'h0};
        vecs[7] = '{t:'{0, 32'h0, 1, 0, 2'd2, 32'h30, 32'h0, 1},
                    if_cyc:-1, if_d:32'h0, mem_cyc:4, mem_d:32'h0000_A5EF};

        for (int i = 0; i < 512; i++) ref_mem[i] = init_byte(9'(i));
        model_last_if = '0; model_last_mem = '0; model_mem_known = 1'b1;
        rst = 1'b0; ram_clr = 1'b1;
        if_req = 0; if_addr = '0; if_flush = 0;
        mem_req = 0; mem_we = 0; mem_sel = 2'd0; mem_addr = '0; mem_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("reset check");
        check("rst ram_a", ram_a, 32'h0);
        check("rst ram_dout", 32'(ram_dout), 32'h0);
        check("rst ram_wr", 32'(ram_wr), 32'h0);
        check("rst if_done", 32'(if_done), 32'h0);
        check("rst mem_done", 32'(mem_done), 32'h0);
        check("rst if_inst", if_inst, 32'h0);
        check("rst mem_rdata", mem_rdata, 32'h0);
        check("rst stall", 32'(stallreq_mem), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1; ram_clr = 1'b0;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].t, ic, id, mc, md);
            check($sformatf("vec%0d if cycle", i), 32'(ic), 32'(vecs[i].if_cyc));
            check($sformatf("vec%0d mem cycle", i), 32'(mc), 32'(vecs[i].mem_cyc));
            if (vecs[i].if_cyc >= 0) check($sformatf("vec%0d if_inst", i), id, vecs[i].if_d);
            if (vecs[i].mem_cyc >= 0 && !vecs[i].t.we)
                check($sformatf("vec%0d mem_rdata", i), md, vecs[i].mem_d);
        end

        // mem_sel=00 requests are ignored
        $display("seq: mem_sel none");
        mem_req = 1; mem_we = 1; mem_sel = 2'd0; mem_addr = 32'h44; mem_wdata = 32'h1234_5678;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("nop ram_wr c%0d", c), 32'(ram_wr), 32'h0);
            check($sformatf("nop mem_done c%0d", c), 32'(mem_done), 32'h0);
            check($sformatf("nop stall c%0d", c), 32'(stallreq_mem), 32'h0);
            @(posedge clk); #1;
        end
        mem_req = 0; mem_we = 0;

        // Flush during an IF read, then a new fetch sampled right after
        $display("seq: if flush mid-read");
        if_req = 1; if_addr = 32'h40;
        for (int c = 0; c <= 10; c++) begin
            if (c == 3) if_flush = 1;
            if (c == 4) begin if_flush = 0; if_addr = 32'h80; end
            @(negedge clk);
            check($sformatf("flush if_done c%0d", c), 32'(if_done), 32'(c == 10));
            check($sformatf("flush ram_wr c%0d", c), 32'(ram_wr), 32'h0);
            if (c >= 1 && c <= 3) check($sformatf("flush ram_a c%0d", c), ram_a, 32'h40 + 32'(c - 1));
            if (c >= 5 && c <= 8) check($sformatf("flush ram_a c%0d", c), ram_a, 32'h80 + 32'(c - 5));
            if (c == 10) check("flush if_inst", if_inst, ref_word(32'h80, 4));
            @(posedge clk); #1;
        end
        if_req = 0;
        model_last_if = ref_word(32'h80, 4);

        // if_req together with if_flush in idle is ignored
        $display("seq: req with flush in idle");
        if_req = 1; if_flush = 1; if_addr = 32'h90;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("idleflush if_done c%0d", c), 32'(if_done), 32'h0);
            check($sformatf("idleflush ram_wr c%0d", c), 32'(ram_wr), 32'h0);
            @(posedge clk); #1;
            if_req = 0; if_flush = 0;
        end

        // Reset in the middle of a word store, request re-sampled afterwards
        $display("seq: reset mid-store");
        mem_req = 1; mem_we = 1; mem_sel = 2'd3; mem_addr = 32'h60; mem_wdata = 32'hA1B2_C3D4;
        for (int c = 0; c <= 8; c++) begin
            if (c == 2) rst = 1'b0;
            if (c == 3) rst = 1'b1;
            @(negedge clk);
            check($sformatf("rstmid mem_done c%0d", c), 32'(mem_done), 32'(c == 8));
            if (c == 3) begin
                check("rstmid ram_a", ram_a, 32'h0);
                check("rstmid ram_dout", 32'(ram_dout), 32'h0);
                check("rstmid ram_wr", 32'(ram_wr), 32'h0);
                check("rstmid if_done", 32'(if_done), 32'h0);
                check("rstmid if_inst", if_inst, 32'h0);
                check("rstmid mem_rdata", mem_rdata, 32'h0);
            end
            if (c >= 4 && c <= 7) begin
                check($sformatf("rstmid ram_wr c%0d", c), 32'(ram_wr), 32'h1);
                check($sformatf("rstmid ram_a c%0d", c), ram_a, 32'h60 + 32'(c - 4));
                check($sformatf("rstmid dout c%0d", c), 32'(ram_dout), 32'((32'hA1B2_C3D4 >> (8 * (c - 4))) & 32'hFF));
            end
            @(posedge clk); #1;
        end
        mem_req = 0; mem_we = 0;
        for (int k = 0; k < 4; k++) ref_mem[midx(32'h60 + 32'(k))] = 8'((32'hA1B2_C3D4 >> (8 * k)) & 32'hFF);
        model_last_if = '0; model_last_mem = '0; model_mem_known = 1'b1;
        t = '{0, 32'h0, 1, 0, 2'd3, 32'h60, 32'h0, 0};
        run_txn(t, ic, id, mc, md);

        // Randomized transactions against the model
        for (int i = 0; i < 40; i++) begin
            int kind = $urandom_range(0, 2);
            t.do_if  = (kind != 1);
            t.do_mem = (kind != 0);
            t.if_a   = rand_addr();
            t.m_a    = rand_addr();
            t.we     = 1'($urandom_range(0, 1));
            t.sel    = 2'($urandom_range(1, 3));
            t.wd     = $urandom;
            t.flush  = (kind == 1) && ($urandom_range(0, 1) == 1);
            run_txn(t, ic, id, mc, md);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
